// File: rtl/area_pkg.sv
// Shared definitions for the area exponent encoder/decoder pair.
// Holds width defaults, the decoder FSM states and the encoder's exponent ceiling.
package area_pkg;

  localparam int DEF_EXP_W  = 5;
  localparam int DEF_AREA_W = 16;
  localparam int MAX_EXP    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/area_decode.sv
// Reconstructs linear pixel areas (lower/upper bound, square side) from an area
// exponent using a one-bit-per-cycle shifter with valid/ready on both sides.
module area_decode
  import area_pkg::*;
#(
  parameter int EXP_W  = DEF_EXP_W,
  parameter int AREA_W = DEF_AREA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [EXP_W-1:0]    in_exp,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [AREA_W-1:0]   area_lo,
  output logic [AREA_W-1:0]   area_hi,
  output logic [AREA_W/2-1:0] side_pix,
  output logic                sat
);

  localparam int CNT_W  = $clog2(AREA_W + 1);
  localparam int SIDE_W = AREA_W / 2;

  state_t             state;
  logic [AREA_W:0]    acc;
  logic [CNT_W-1:0]   cnt;
  logic [EXP_W-1:0]   e;
  logic [CNT_W-1:0]   ec;

  logic               lo_sat;
  logic               hi_sat;
  logic               side_sat;
  logic [AREA_W-1:0]  lo_val;
  logic [AREA_W-1:0]  hi_val;
  logic [SIDE_W-1:0]  side_val;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Shift count is clamped so acc never grows past 2^AREA_W.
  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    ec = CNT_W'(AREA_W);
    if (int'(in_exp) < AREA_W) ec = CNT_W'(in_exp);
  end

  // acc reaches bit AREA_W exactly when e >= AREA_W, which is the area_lo overflow.
  assign lo_sat   = acc[AREA_W];
  assign hi_sat   = (int'(e) + 2) > AREA_W;
  assign side_sat = int'(e >> 1) >= SIDE_W;

  assign lo_val   = lo_sat   ? '1 : acc[AREA_W-1:0];
  assign hi_val   = hi_sat   ? '1 : ({acc[AREA_W-3:0], 2'b00} - AREA_W'(1));
  assign side_val = side_sat ? '1 : (SIDE_W'(1) << (e >> 1));

  // NOTE: state and data registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      e        <= '0;
      area_lo  <= '0;
      area_hi  <= '0;
      side_pix <= '0;
      sat      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            e     <= in_exp;
            acc   <= {{AREA_W{1'b0}}, 1'b1};
            cnt   <= ec;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            acc <= acc << 1;
            cnt <= cnt - CNT_W'(1);
          end else begin
            area_lo  <= lo_val;
            area_hi  <= hi_val;
            side_pix <= side_val;
            sat      <= lo_sat | hi_sat | side_sat;
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_area_decode.sv
// Self-checking bench for area_decode: vector table, hand-written backpressure and
// reset sequences, then random exponents against an arithmetic reference model.
module tb_area_decode;

  localparam int EXP_W  = 5;
  localparam int AREA_W = 16;
  localparam longint FULL  = (longint'(1) << AREA_W) - 1;
  localparam longint SFULL = (longint'(1) << (AREA_W / 2)) - 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [EXP_W-1:0]    in_exp;
  logic                out_valid;
  logic                out_ready;
  logic [AREA_W-1:0]   area_lo;
  logic [AREA_W-1:0]   area_hi;
  logic [AREA_W/2-1:0] side_pix;
  logic                sat;

  int checks = 0;
  int errors = 0;

  area_decode #(.EXP_W(EXP_W), .AREA_W(AREA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .area_lo   (area_lo),
    .area_hi   (area_hi),
    .side_pix  (side_pix),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     e;
    longint lo;
    longint hi;
    longint side;
    bit     s;
    int     lat;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain powers of two clipped to the output range.
  function automatic vec_t model(input int e);
    vec_t v;
    v.e    = e;
    v.s    = 1'b0;
    v.lo   = longint'(1) << e;
    v.hi   = (longint'(1) << (e + 2)) - 1;
    v.side = longint'(1) << (e / 2);
    if (v.lo > FULL)    begin v.lo = FULL;    v.s = 1'b1; end
    if (v.hi > FULL)    begin v.hi = FULL;    v.s = 1'b1; end
    if (v.side > SFULL) begin v.side = SFULL; v.s = 1'b1; end
    v.lat = ((e < AREA_W) ? e : AREA_W) + 1;
    return v;
  endfunction

  // Accepts one exponent, measures latency, checks results, then completes the handshake.
  task automatic run_item(input vec_t v, input int hold, input string tag);
    int lat;
    @(negedge clk);
    in_exp    = EXP_W'(v.e);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    check({tag, ".in_ready"}, longint'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, ".latency"}, lat, v.lat);
    check({tag, ".area_lo"}, longint'(area_lo), v.lo);
    check({tag, ".area_hi"}, longint'(area_hi), v.hi);
    check({tag, ".side_pix"}, longint'(side_pix), v.side);
    check({tag, ".sat"}, longint'(sat), longint'(v.s));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, ".hold_valid"}, longint'(out_valid), 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".after_valid"}, longint'(out_valid), 0);
    check({tag, ".after_ready"}, longint'(in_ready), 1);
  endtask

  initial begin
    vec_t vecs[8];
    vec_t v;
    int   lat;
    bit   seen;

    vecs[0] = '{e: 0,  lo: 1,     hi: 3,     side: 1,   s: 1'b0, lat: 1};
    vecs[1] = '{e: 1,  lo: 2,     hi: 7,     side: 1,   s: 1'b0, lat: 2};
    vecs[2] = '{e: 4,  lo: 16,    hi: 63,    side: 4,   s: 1'b0, lat: 5};
    vecs[3] = '{e: 9,  lo: 512,   hi: 2047,  side: 16,  s: 1'b0, lat: 10};
    vecs[4] = '{e: 14, lo: 16384, hi: 65535, side: 128, s: 1'b0, lat: 15};
    vecs[5] = '{e: 15, lo: 32768, hi: 65535, side: 128, s: 1'b1, lat: 16};
    vecs[6] = '{e: 16, lo: 65535, hi: 65535, side: 255, s: 1'b1, lat: 17};
    vecs[7] = '{e: 31, lo: 65535, hi: 65535, side: 255, s: 1'b1, lat: 17};

    rst = 1'b1; in_valid = 1'b0; in_exp = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset.in_ready", longint'(in_ready), 1);
    check("reset.out_valid", longint'(out_valid), 0);
    check("reset.area_lo", longint'(area_lo), 0);
    check("reset.area_hi", longint'(area_hi), 0);
    check("reset.side_pix", longint'(side_pix), 0);
    check("reset.sat", longint'(sat), 0);

    for (int i = 0; i < 8; i++) run_item(vecs[i], 0, $sformatf("vec%0d", vecs[i].e));

    // Backpressure: first item held, a second request waits until IDLE.
    @(negedge clk);
    in_exp = 5'd4; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_exp = 5'd9;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("bp.latency", lat, 5);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp.out_valid", longint'(out_valid), 1);
      check("bp.in_ready", longint'(in_ready), 0);
      check("bp.area_lo", longint'(area_lo), 16);
      check("bp.area_hi", longint'(area_hi), 63);
      check("bp.side_pix", longint'(side_pix), 4);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp.release_valid", longint'(out_valid), 0);
    check("bp.release_ready", longint'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp.second_accepted", longint'(in_ready), 0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("bp.second_latency", lat, 10);
    check("bp.second_lo", longint'(area_lo), 512);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of a long shift discards the item.
    in_exp = 5'd12; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst.in_ready", longint'(in_ready), 1);
    check("midrst.area_lo", longint'(area_lo), 0);
    check("midrst.area_hi", longint'(area_hi), 0);
    check("midrst.side_pix", longint'(side_pix), 0);
    check("midrst.sat", longint'(sat), 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midrst.no_output", longint'(seen), 0);

    for (int i = 0; i < 40; i++) begin
      v = model(int'($urandom_range(0, 31)));
      run_item(v, int'($urandom_range(0, 3)), $sformatf("rnd%0d_e%0d", i, v.e));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/area_decode.md
Name: area_decode

Overview:
- Inverse of the log2 area encoder: takes an area exponent e = msb(xspan) + msb(yspan) and reconstructs linear pixel-area values.
- Outputs: lower bound 2^e, upper bound 2^(e+2)-1, and square-side estimate 2^floor(e/2).
- Sits downstream of the area-exponent register. Feeds the blob-size filter and overlay logic that need linear areas.
- Iterative shifter, one bit per cycle, with valid/ready handshake on both sides.

Parameters:
- EXP_W, 5, width of the input exponent (encoder range 0..16).
- AREA_W, 16, width of the linear area outputs.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, exponent valid.
- in_ready, output, 1, block can accept an exponent.
- in_exp, input, EXP_W, area exponent e.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts result.
- area_lo, output, AREA_W, 2^e, saturated.
- area_hi, output, AREA_W, 2^(e+2)-1, saturated.
- side_pix, output, AREA_W/2, 2^floor(e/2), saturated.
- sat, output, 1, at least one output saturated.

Behaviour:
- Clock and reset: clk; reset rst, synchronous, active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, area_lo=0, area_hi=0, side_pix=0, sat=0, internal cnt/acc=0.
- Reset mid-operation aborts the computation; the held result is discarded and nothing is emitted.
- FSM states: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE), combinational from state. out_valid = (state==DONE).
- IDLE: on in_valid && in_ready at an edge:
  - ec = min(in_exp, AREA_W); store e = in_exp.
  - acc<=1, cnt<=ec, state<=SHIFT.
- SHIFT, each edge:
  - If cnt!=0: acc<=acc<<1 (AREA_W+1 bits internal), cnt<=cnt-1.
  - If cnt==0: load outputs from acc and e, state<=DONE.
- Latency: out_valid rises ec+1 edges after the accept edge (e=0 gives 1 cycle; e>=AREA_W gives AREA_W+1 cycles).
- Output rules:
  - area_lo = 2^e if e<AREA_W, else all ones with sat=1.
  - area_hi = 2^(e+2)-1 if e+2<=AREA_W, else all ones with sat=1.
  - side_pix = 2^floor(e/2) if floor(e/2)<AREA_W/2, else all ones with sat=1.
  - sat is the OR of the three saturation conditions.
- DONE: outputs and out_valid hold stable while out_ready=0. On an out_ready edge: state<=IDLE, out_valid<=0. Output data regs keep their last value.
- Throughput: minimum ec+3 cycles per item (IDLE cycle, SHIFT cycles, DONE cycle). A new input is never accepted in the same cycle as an output handshake.
- in_exp and in_valid are ignored outside IDLE. The upstream holds data until in_ready.
- in_exp values above 2*(AREA_W/2) are legal and saturate.

Decomposition:
- Shared package area_pkg: EXP_W and AREA_W defaults, the FSM state enum, and localparam MAX_EXP = 16 (encoder maximum), shared with the encoder side.
- No sub-module: acc, cnt and the saturation compare live in one module. Bound computation is registered at the SHIFT->DONE edge from acc and e.

Test Plan:
- Reset: assert rst 2 cycles -> in_ready=1, out_valid=0, all outputs 0, sat=0.
- e=0, out_ready=1 -> out_valid 1 cycle after accept; area_lo=1, area_hi=3, side_pix=1, sat=0; returns to IDLE next edge.
- e=9 -> out_valid after 10 cycles; area_lo=512, area_hi=2047, side_pix=16, sat=0.
- e=15 -> area_lo=32768, area_hi=65535, sat=1 (hi saturated). e=16 -> area_lo=65535, side_pix=255, sat=1, latency 17 cycles.
- Backpressure: e=4, out_ready=0 for 5 cycles -> outputs hold 16/63/4, out_valid stays high, in_ready stays 0, a second in_valid is ignored; release out_ready -> one handshake, then the second item is accepted from IDLE.
- Reset mid-SHIFT: e=12, assert rst after 5 cycles -> out_valid never rises, outputs 0, in_ready=1 the cycle after rst deasserts.
